// File: rtl/backprop_weight_update_pkg.sv
// Shared types and saturating fixed-point helpers for the weight-update block.
package backprop_weight_update_pkg;

  localparam int unsigned FracBitsDefault = 4;

  typedef enum logic [1:0] {StIdle, StCollect, StUpdate, StDone} state_e;

  // Clamp to the signed range of a w-bit two's complement value.
  function automatic longint sat_clip(input longint v, input int unsigned w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint sat_add(input longint a, input longint b, input int unsigned w);
    return sat_clip(a + b, w);
  endfunction

  // Full-precision product, floor shift back to the fixed-point scale, then clamp.
  function automatic longint sat_mult(input longint a, input longint b, input int unsigned w,
                                      input int unsigned fb);
    return sat_clip((a * b) >>> fb, w);
  endfunction

endpackage

// File: rtl/backprop_weight_row_alu.sv
// Combinational row datapath: each lane computes sat(w - sat_mult(lr, g)).
module backprop_weight_row_alu
  import backprop_weight_update_pkg::*;
#(
  parameter int unsigned data_size = 8,
  parameter int unsigned size      = 3,
  parameter int unsigned frac_bits = FracBitsDefault
) (
  input  logic [data_size-1:0]      lr,
  input  logic [data_size*size-1:0] w_row,
  input  logic [data_size*size-1:0] g_row,
  output logic [data_size*size-1:0] new_row
);

  // One lane per column; element 0 sits in the most significant slot.
  always_comb begin
    new_row = '0;
    for (int c = 0; c < size; c++) begin
      new_row[(size-c)*data_size-1 -: data_size] = data_size'(sat_add(
          longint'($signed(w_row[(size-c)*data_size-1 -: data_size])),
          -sat_mult(longint'($signed(lr)),
                    longint'($signed(g_row[(size-c)*data_size-1 -: data_size])),
                    data_size, frac_bits),
          data_size));
    end
  end

endmodule

// File: rtl/backprop_weight_update.sv
// Gradient collector and per-layer weight store applying w <- w - lr*g row by row.
module backprop_weight_update
  import backprop_weight_update_pkg::*;
#(
  parameter int unsigned data_size      = 8,
  parameter int unsigned size           = 3,
  parameter int unsigned max_layer_size = 4,
  parameter int unsigned frac_bits      = FracBitsDefault
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [32:0]               layer_index,
  input  logic [data_size-1:0]      learning_rate,
  input  logic                      dc_dw_valid,
  input  logic [data_size*size-1:0] dc_dw_stream,
  input  logic                      load_en,
  input  logic [32:0]               load_layer,
  input  logic [32:0]               load_row,
  input  logic [data_size*size-1:0] load_weights,
  input  logic [32:0]               rd_layer,
  input  logic [32:0]               rd_row,
  output logic [data_size*size-1:0] rd_weights,
  output logic                      busy,
  output logic                      weight_valid,
  output logic [32:0]               weight_row_index,
  output logic [data_size*size-1:0] weight_stream,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned RowW   = data_size * size;
  localparam int unsigned LayerW = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
  localparam int unsigned CntW   = (size > 1) ? $clog2(size) : 1;
  localparam logic [32:0] MaxLayer = 33'(max_layer_size);
  localparam logic [32:0] NumRows  = 33'(size);
  localparam logic [CntW-1:0] LastRow = CntW'(size - 1);

  state_e              state;
  logic [LayerW-1:0]   layer;
  logic [data_size-1:0] lr;
  logic [CntW-1:0]     row_cnt;
  logic [RowW-1:0]     grad [size];
  logic [RowW-1:0]     weights [max_layer_size][size];
  logic [RowW-1:0]     new_row;
  logic                start_ok;
  logic                load_ok;

  assign start_ok = layer_index < MaxLayer;
  assign load_ok  = load_en && (load_layer < MaxLayer) && (load_row < NumRows);

  backprop_weight_row_alu #(
    .data_size(data_size),
    .size     (size),
    .frac_bits(frac_bits)
  ) u_alu (
    .lr     (lr),
    .w_row  (weights[layer][row_cnt]),
    .g_row  (grad[row_cnt]),
    .new_row(new_row)
  );

  // Asynchronous-looking read port: out-of-range indices return zero rather than aliasing.
  always_comb begin
    rd_weights = '0;
    if ((rd_layer < MaxLayer) && (rd_row < NumRows)) begin
      rd_weights = weights[rd_layer[LayerW-1:0]][rd_row[CntW-1:0]];
    end
  end

  // Control FSM, weight store and registered outputs.
  // busy stays high for one IDLE cycle after DONE, so a new start waits for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= StIdle;
      layer            <= '0;
      lr               <= '0;
      row_cnt          <= '0;
      busy             <= 1'b0;
      weight_valid     <= 1'b0;
      weight_row_index <= '0;
      weight_stream    <= '0;
      done             <= 1'b0;
      err              <= 1'b0;
      for (int r = 0; r < size; r++) grad[r] <= '0;
      for (int l = 0; l < max_layer_size; l++) begin
        for (int r = 0; r < size; r++) weights[l][r] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        StIdle: begin
          weight_valid <= 1'b0;
          busy         <= 1'b0;
          if (!busy) begin
            if (load_ok) weights[load_layer[LayerW-1:0]][load_row[CntW-1:0]] <= load_weights;
            if (start) begin
              if (start_ok) begin
                layer   <= layer_index[LayerW-1:0];
                lr      <= learning_rate;
                row_cnt <= '0;
                busy    <= 1'b1;
                state   <= StCollect;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        StCollect: begin
          if (dc_dw_valid) begin
            grad[row_cnt] <= dc_dw_stream;
            if (row_cnt == LastRow) begin
              row_cnt <= '0;
              state   <= StUpdate;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        StUpdate: begin
          weights[layer][row_cnt] <= new_row;
          weight_valid            <= 1'b1;
          weight_row_index        <= 33'(row_cnt);
          weight_stream           <= new_row;
          if (row_cnt == LastRow) begin
            row_cnt <= '0;
            state   <= StDone;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        StDone: begin
          done         <= 1'b1;
          weight_valid <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_backprop_weight_update.sv
// Randomized self-checking bench for backprop_weight_update against an arithmetic model.
module tb_backprop_weight_update;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [32:0] layer_index = '0;
  logic [7:0]  learning_rate = '0;
  logic        dc_dw_valid = 1'b0;
  logic [23:0] dc_dw_stream = '0;
  logic        load_en = 1'b0;
  logic [32:0] load_layer = '0;
  logic [32:0] load_row = '0;
  logic [23:0] load_weights = '0;
  logic [32:0] rd_layer = '0;
  logic [32:0] rd_row = '0;
  logic [23:0] rd_weights;
  logic        busy;
  logic        weight_valid;
  logic [32:0] weight_row_index;
  logic [23:0] weight_stream;
  logic        done;
  logic        err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference state: plain integer weights per layer/row/column.
  int          mw [4][3][3];
  logic [23:0] tg [3];
  bit          vpat [8];
  int          pat_len;

  backprop_weight_update #(
    .data_size     (8),
    .size          (3),
    .max_layer_size(4),
    .frac_bits     (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .layer_index     (layer_index),
    .learning_rate   (learning_rate),
    .dc_dw_valid     (dc_dw_valid),
    .dc_dw_stream    (dc_dw_stream),
    .load_en         (load_en),
    .load_layer      (load_layer),
    .load_row        (load_row),
    .load_weights    (load_weights),
    .rd_layer        (rd_layer),
    .rd_row          (rd_row),
    .rd_weights      (rd_weights),
    .busy            (busy),
    .weight_valid    (weight_valid),
    .weight_row_index(weight_row_index),
    .weight_stream   (weight_stream),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // New weight = clamp(w - clamp(floor(lr*g / 16))).
  function automatic int ref_elem(input int w, input int lr, input int g);
    int p;
    int m;
    p = lr * g;
    if (p >= 0) m = p / 16;
    else m = -((-p + 15) / 16);
    return clamp8(w - clamp8(m));
  endfunction

  function automatic int elem_of(input logic [23:0] row, input int c);
    logic signed [7:0] e;
    e = row[(3-c)*8-1 -: 8];
    return int'(e);
  endfunction

  function automatic logic [23:0] pack3(input int a, input int b, input int c);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    x = a[7:0];
    y = b[7:0];
    z = c[7:0];
    return {x, y, z};
  endfunction

  function automatic logic [23:0] model_row(input int l, input int r);
    return pack3(mw[l][r][0], mw[l][r][1], mw[l][r][2]);
  endfunction

  function automatic int rand_s8();
    int u;
    u = int'($urandom_range(0, 255));
    return (u > 127) ? u - 256 : u;
  endfunction

  task automatic clear_model();
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) mw[l][r][c] = 0;
  endtask

  // Direct row write while idle; the model only takes in-range writes.
  task automatic do_load(input logic [32:0] l, input logic [32:0] r, input logic [23:0] data);
    @(negedge clk);
    load_en = 1'b1;
    load_layer = l;
    load_row = r;
    load_weights = data;
    if (l < 4 && r < 3)
      for (int c = 0; c < 3; c++) mw[l][r][c] = elem_of(data, c);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Compare every stored row and the out-of-range reads with the model.
  task automatic test_readback(input string tag);
    for (int l = 0; l < 4; l++) begin
      for (int r = 0; r < 3; r++) begin
        rd_layer = 33'(l);
        rd_row = 33'(r);
        #1;
        chk_cnt++;
        if (rd_weights !== model_row(l, r))
          $display("FAIL %s rd_weights[%0d][%0d] got %h expected %h", tag, l, r, rd_weights,
                   model_row(l, r));
        else pass_cnt++;
      end
    end
    rd_layer = 33'd4;
    rd_row = 33'd0;
    #1;
    chk_cnt++;
    if (rd_weights !== 24'h0) $display("FAIL %s rd layer 4 got %h expected 0", tag, rd_weights);
    else pass_cnt++;
    rd_layer = 33'h1_0000_0001;
    #1;
    chk_cnt++;
    if (rd_weights !== 24'h0) $display("FAIL %s rd layer 2^32+1 got %h expected 0", tag, rd_weights);
    else pass_cnt++;
    rd_layer = 33'd0;
    rd_row = 33'd3;
    #1;
    chk_cnt++;
    if (rd_weights !== 24'h0) $display("FAIL %s rd row 3 got %h expected 0", tag, rd_weights);
    else pass_cnt++;
    rd_row = 33'd0;
  endtask

  // One full layer update: start, gradient rows per vpat (then valid held high), checks on
  // every streamed row, done/busy timing, and a final readback.
  task automatic run_layer(input string tag, input int layer, input int lr, input bit noise,
                           input bit with_load, input int ld_row, input logic [23:0] ld_data);
    logic [23:0] exp_rows [3];
    int k;
    int i;
    bit v;
    @(negedge clk);
    start = 1'b1;
    layer_index = 33'(layer);
    learning_rate = 8'(lr);
    dc_dw_valid = 1'b0;
    if (with_load) begin
      load_en = 1'b1;
      load_layer = 33'(layer);
      load_row = 33'(ld_row);
      load_weights = ld_data;
      for (int c = 0; c < 3; c++) mw[layer][ld_row][c] = elem_of(ld_data, c);
    end
    @(posedge clk);
    k = 0;
    i = 0;
    while (k < 3) begin
      @(negedge clk);
      start = 1'b0;
      load_en = 1'b0;
      v = (i < pat_len) ? vpat[i] : 1'b1;
      i++;
      dc_dw_valid = v;
      dc_dw_stream = v ? tg[k] : 24'($urandom());
      if (noise && !v) begin
        start = 1'b1;
        layer_index = 33'($urandom_range(0, 3));
        learning_rate = 8'($urandom());
        load_en = 1'b1;
        load_layer = 33'($urandom_range(0, 3));
        load_row = 33'($urandom_range(0, 2));
        load_weights = 24'($urandom());
      end
      @(posedge clk);
      if (v) k++;
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) mw[layer][r][c] = ref_elem(mw[layer][r][c], lr, elem_of(tg[r], c));
      exp_rows[r] = model_row(layer, r);
    end
    @(negedge clk);
    start = 1'b0;
    load_en = 1'b0;
    dc_dw_valid = noise;
    dc_dw_stream = 24'($urandom());
    chk_cnt++;
    if (busy !== 1'b1 || weight_valid !== 1'b0)
      $display("FAIL %s collect-end busy/weight_valid got %b%b expected 10", tag, busy, weight_valid);
    else pass_cnt++;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (noise) begin
        start = 1'b1;
        layer_index = 33'($urandom_range(0, 3));
        load_en = 1'b1;
        load_layer = 33'(layer);
        load_row = 33'(j);
        load_weights = 24'($urandom());
      end
      chk_cnt++;
      if (weight_valid !== 1'b1 || weight_row_index !== 33'(j) || weight_stream !== exp_rows[j])
        $display("FAIL %s row %0d valid/index/stream got %b/%0d/%h expected 1/%0d/%h", tag, j,
                 weight_valid, weight_row_index, weight_stream, j, exp_rows[j]);
      else pass_cnt++;
    end
    @(negedge clk);
    start = 1'b0;
    load_en = 1'b0;
    dc_dw_valid = 1'b0;
    chk_cnt++;
    if (done !== 1'b1 || weight_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s done-cycle done/weight_valid/busy got %b%b%b expected 101", tag, done,
               weight_valid, busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after-done done/busy got %b%b expected 00", tag, done, busy);
    else pass_cnt++;
    test_readback(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_model();
    chk_cnt++;
    if ({busy, weight_valid, done, err} !== 4'b0 || weight_row_index !== 33'd0 ||
        weight_stream !== 24'h0)
      $display("FAIL reset outputs got busy=%b wv=%b done=%b err=%b idx=%0d ws=%h expected all 0",
               busy, weight_valid, done, err, weight_row_index, weight_stream);
    else pass_cnt++;
    test_readback("reset");
  endtask

  task automatic test_basic();
    for (int r = 0; r < 3; r++) do_load(33'd1, 33'(r), pack3(32, 32, 32));
    for (int r = 0; r < 3; r++) tg[r] = pack3(16, 16, 16);
    pat_len = 0;
    run_layer("basic", 1, 16, 1'b0, 1'b0, 0, 24'h0);
    rd_layer = 33'd1;
    rd_row = 33'd2;
    #1;
    chk_cnt++;
    if (rd_weights !== pack3(16, 16, 16))
      $display("FAIL basic rd layer1 row2 got %h expected %h", rd_weights, pack3(16, 16, 16));
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_load(33'd0, 33'd0, pack3(-128, -128, -128));
    do_load(33'd0, 33'd1, pack3(127, 127, 127));
    do_load(33'd0, 33'd2, pack3(5, -7, 100));
    tg[0] = pack3(16, 16, 16);
    tg[1] = pack3(-16, -16, -16);
    tg[2] = 24'($urandom());
    pat_len = 0;
    run_layer("sat", 0, 16, 1'b0, 1'b0, 0, 24'h0);
    rd_layer = 33'd0;
    rd_row = 33'd0;
    #1;
    chk_cnt++;
    if (rd_weights !== pack3(-128, -128, -128))
      $display("FAIL sat low rail got %h expected 808080", rd_weights);
    else pass_cnt++;
    rd_row = 33'd1;
    #1;
    chk_cnt++;
    if (rd_weights !== pack3(127, 127, 127))
      $display("FAIL sat high rail got %h expected 7f7f7f", rd_weights);
    else pass_cnt++;
    // Half learning rate with a small negative gradient: floor(-24/16) = -2.
    do_load(33'd0, 33'd0, pack3(0, 0, 0));
    for (int r = 0; r < 3; r++) tg[r] = pack3(-3, -3, -3);
    run_layer("floor", 0, 8, 1'b0, 1'b0, 0, 24'h0);
    rd_layer = 33'd0;
    rd_row = 33'd0;
    #1;
    chk_cnt++;
    if (rd_weights !== pack3(2, 2, 2))
      $display("FAIL floor product got %h expected 020202", rd_weights);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) tg[r] = 24'($urandom());
    vpat[0] = 1'b1;
    vpat[1] = 1'b0;
    vpat[2] = 1'b0;
    vpat[3] = 1'b1;
    vpat[4] = 1'b1;
    pat_len = 5;
    run_layer("gaps", 2, rand_s8(), 1'b1, 1'b0, 0, 24'h0);
  endtask

  task automatic test_err();
    int saved_lr;
    saved_lr = rand_s8();
    @(negedge clk);
    start = 1'b1;
    layer_index = 33'd4;
    learning_rate = 8'(saved_lr);
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (err !== 1'b1 || busy !== 1'b0)
      $display("FAIL err pulse err/busy got %b%b expected 10", err, busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (err !== 1'b0 || busy !== 1'b0)
      $display("FAIL err clear err/busy got %b%b expected 00", err, busy);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b1;
    layer_index = 33'h1_0000_0001;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (err !== 1'b1 || busy !== 1'b0)
      $display("FAIL err wide index err/busy got %b%b expected 10", err, busy);
    else pass_cnt++;
    do_load(33'd4, 33'd0, 24'hABCDEF);
    do_load(33'd0, 33'd3, 24'h123456);
    do_load(33'h1_0000_0002, 33'd1, 24'h654321);
    test_readback("err");
  endtask

  task automatic test_load_and_start();
    for (int r = 0; r < 3; r++) tg[r] = 24'($urandom());
    pat_len = 0;
    run_layer("load+start", 3, rand_s8(), 1'b0, 1'b1, 1, pack3(rand_s8(), rand_s8(), rand_s8()));
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    layer_index = 33'd2;
    learning_rate = 8'd16;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dc_dw_valid = 1'b1;
    dc_dw_stream = 24'($urandom());
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dc_dw_valid = 1'b0;
    clear_model();
    chk_cnt++;
    if ({busy, weight_valid, done, err} !== 4'b0 || weight_row_index !== 33'd0 ||
        weight_stream !== 24'h0)
      $display("FAIL midreset outputs got busy=%b wv=%b done=%b err=%b idx=%0d ws=%h expected 0",
               busy, weight_valid, done, err, weight_row_index, weight_stream);
    else pass_cnt++;
    test_readback("midreset");
    for (int r = 0; r < 3; r++) tg[r] = 24'($urandom());
    pat_len = 0;
    run_layer("after-reset", 2, rand_s8(), 1'b0, 1'b0, 0, 24'h0);
  endtask

  task automatic test_random();
    int layer;
    for (int it = 0; it < 6; it++) begin
      layer = int'($urandom_range(0, 3));
      for (int r = 0; r < 3; r++) do_load(33'(layer), 33'(r), 24'($urandom()));
      for (int r = 0; r < 3; r++) tg[r] = 24'($urandom());
      pat_len = int'($urandom_range(0, 6));
      for (int p = 0; p < 8; p++) vpat[p] = 1'($urandom());
      run_layer("random", layer, rand_s8(), 1'b1, 1'b0, 0, 24'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_gaps();
    test_err();
    test_load_and_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/backprop_weight_update.md
Name: backprop_weight_update

Overview:
- Consumer end of the backprop gradient stream. Collects `size` consecutive dc_dw_stream rows into one size×size gradient matrix for a layer.
- Applies w ← w − lr·g to that layer's weights, one row per cycle, in saturating fixed point, and streams the updated rows out.
- Holds the weight store for `max_layer_size` layers. Sits downstream of the backprop stack and upstream of the forward dense layers.

Parameters:
- data_size, 8, element width in bits, signed two's complement
- size, 3, elements per row; rows per layer
- max_layer_size, 4, number of layers held
- frac_bits, 4, fractional bits of the fixed-point format (1.0 = 2^frac_bits)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin one layer update
- layer_index  in  33  target layer, sampled with start
- learning_rate  in  data_size  signed fixed-point lr, sampled with start
- dc_dw_valid  in  1  dc_dw_stream holds a valid gradient row this cycle
- dc_dw_stream  in  data_size*size  gradient row; element i at [(size−i)*data_size−1 -: data_size]
- load_en  in  1  write one weight row directly (IDLE only)
- load_layer  in  33  layer for load_en
- load_row  in  33  row for load_en
- load_weights  in  data_size*size  row data for load_en, same packing
- rd_layer  in  33  combinational read layer
- rd_row  in  33  combinational read row
- rd_weights  out  data_size*size  weights[rd_layer][rd_row]; 0 if either index is out of range
- busy  out  1  high in any state other than IDLE
- weight_valid  out  1  weight_stream carries an updated row
- weight_row_index  out  33  row index for weight_stream
- weight_stream  out  data_size*size  updated row, same packing
- done  out  1  one-cycle pulse when the update completes
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Clock is clk; reset is synchronous and active-high. On reset: state IDLE; all counters, the gradient buffer and all weights cleared to 0; busy, weight_valid, done and err are 0; weight_row_index and weight_stream are 0. Reset overrides every other input, including mid-COLLECT and mid-UPDATE.
- FSM states are IDLE, COLLECT, UPDATE and DONE. Transitions:
  - IDLE, start=1, layer_index < max_layer_size: latch layer and lr, row_cnt←0, go to COLLECT.
  - IDLE, start=1, layer_index ≥ max_layer_size: err=1 for one cycle, stay in IDLE.
  - COLLECT: on each edge with dc_dw_valid=1, g[row_cnt] ← row and row_cnt++. An edge with dc_dw_valid=0 holds (gaps are allowed). The edge that accepts row size−1 moves to UPDATE with row_cnt←0.
  - UPDATE: each edge, for every column c, w[L][r][c] ← sat(w[L][r][c] − sat(mult(lr, g[r][c]))). The same edge registers weight_valid=1, weight_row_index=r and weight_stream=new row. After row size−1, go to DONE.
  - DONE: done=1 for one cycle, weight_valid=0, go to IDLE.
- dc_dw_valid is ignored outside COLLECT. start is ignored while busy.
- load_en is honoured only in IDLE with in-range indices; otherwise it is ignored. If start and load_en are asserted in the same IDLE cycle, the load is performed and start is also accepted.
- Arithmetic:
  - mult = full-precision product (2·data_size bits), arithmetic shift right by frac_bits (floor), then saturate.
  - Subtract is done at data_size+1 bits, then saturated.
  - Saturation range is [−2^(data_size−1), 2^(data_size−1)−1].
- Latency, with dc_dw_valid held high and start accepted at edge 0:
  - rows are accepted at edges 1..size;
  - weight_valid is high after edges size+1..2·size;
  - done is high after edge 2·size+1;
  - busy falls after edge 2·size+2.
- rd_weights reflects an update from the edge after it is written.

Decomposition:
- Shared include, with the gdo parameter file: frac_bits default, sat_add, sat_mult and state encodings.
- One sub-module, backprop_weight_row_alu. It is combinational: `size` lanes, each computing sat(w − sat_mult(lr, g)), and it is instantiated once.

Test Plan (data_size=8, size=3, frac_bits=4):
- Load layer 1 rows with 32 (2.0). Start layer 1 with lr=16 (1.0) and three gradient rows of 16 → weight_stream rows all 16, weight_row_index 0,1,2, done after edge 7, rd_weights=16.
- Weight −128, lr=16, g=16 → stays −128 (saturation). Weight 127, g=−16 → stays 127.
- lr=8 (0.5), g=−3, w=0 → product floor(−24/16) = −2 → new weight 2.
- dc_dw_valid pattern 1,0,0,1,1 → exactly 3 rows captured in order. Updates start after the third valid row. A start pulse during busy is ignored.
- start with layer_index=4 → err pulse, busy stays 0, all weights unchanged.
- Assert reset in the second COLLECT cycle → next cycle busy=0 and all outputs 0. A new start then runs normally from row 0.
